// File: rtl/sa_pkg.sv
// sa_pkg: shared systolic-array constants and feed controller state encoding
package sa_pkg;
    localparam int N = 4;
    localparam int KMAX = 16;
    localparam int W = 16;
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
endpackage

// File: rtl/sa_skew_mask.sv
// sa_skew_mask: diagonal wavefront mask, column j live for t in [j, j+klen_q)
module sa_skew_mask #(
    parameter int N = 4,
    parameter int KMAX = 16
) (
    input  logic [$clog2(KMAX+N)-1:0] t,
    input  logic [$clog2(KMAX):0]     klen_q,
    output logic [N-1:0]              mask
);
    for (genvar j = 0; j < N; j++) begin : g_col
        assign mask[j] = (int'(t) >= j) && (int'(t) < j + int'(klen_q));
    end
endmodule

// File: rtl/sa_feed_ctrl.sv
// sa_feed_ctrl: sequences clear, skewed operand feed and drain of an NxN systolic array
module sa_feed_ctrl #(
    parameter int N = sa_pkg::N,
    parameter int KMAX = sa_pkg::KMAX
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic                      start,
    input  logic [$clog2(KMAX):0]     k_len,
    input  logic                      stall,
    output logic                      busy,
    output logic                      done,
    output logic                      arr_clr,
    output logic                      arr_en,
    output logic [$clog2(KMAX)-1:0]   rd_addr,
    output logic                      rd_valid,
    output logic [N-1:0]              col_valid,
    output logic                      err
);
    import sa_pkg::*;
    localparam int KW = $clog2(KMAX) + 1;
    localparam int AW = $clog2(KMAX);
    localparam int TW = $clog2(KMAX + N);
    localparam int DW = $clog2(N + 1);

    state_t          st, st_nxt;
    logic [TW-1:0]   t, t_nxt, t_last;
    logic [DW-1:0]   dc, dc_nxt;
    logic [KW-1:0]   klen_q, klen_nxt;
    logic [N-1:0]    mask;
    logic            err_nxt, rv_nxt, legal;

    assign legal  = (k_len != '0) && (k_len <= KW'(KMAX));
    assign t_last = TW'(klen_q) + TW'(N - 2);
    assign rv_nxt = (st_nxt == FEED) && (t_nxt < TW'(klen_nxt));

    sa_skew_mask #(.N(N), .KMAX(KMAX)) u_mask (
        .t      (t_nxt),
        .klen_q (klen_nxt),
        .mask   (mask)
    );

    // next state and counters; stall freezes FEED/DRAIN but never CLEAR
    always_comb begin
        st_nxt   = st;
        t_nxt    = t;
        dc_nxt   = dc;
        klen_nxt = klen_q;
        err_nxt  = 1'b0;
        case (st)
            IDLE: begin
                if (start && legal) begin
                    st_nxt   = CLEAR;
                    klen_nxt = k_len;
                end else if (start) begin
                    err_nxt = 1'b1;
                end
            end
            CLEAR: begin
                st_nxt = FEED;
                t_nxt  = '0;
            end
            FEED: begin
                if (!stall && t == t_last) begin
                    st_nxt = DRAIN;
                    dc_nxt = '0;
                end else if (!stall) begin
                    t_nxt = t + TW'(1);
                end
            end
            DRAIN: begin
                if (!stall && dc == DW'(N - 1)) st_nxt = DONE;
                else if (!stall) dc_nxt = dc + DW'(1);
            end
            DONE: begin
                st_nxt = IDLE;
                t_nxt  = '0;
            end
            default: st_nxt = IDLE;
        endcase
    end

    // state plus outputs registered from the upcoming state so they change on the entering edge
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            st        <= IDLE;
            t         <= '0;
            dc        <= '0;
            klen_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            arr_clr   <= 1'b0;
            arr_en    <= 1'b0;
            rd_addr   <= '0;
            rd_valid  <= 1'b0;
            col_valid <= '0;
            err       <= 1'b0;
        end else begin
            st        <= st_nxt;
            t         <= t_nxt;
            dc        <= dc_nxt;
            klen_q    <= klen_nxt;
            busy      <= st_nxt != IDLE;
            done      <= st_nxt == DONE;
            arr_clr   <= st_nxt == CLEAR;
            arr_en    <= (st_nxt == FEED || st_nxt == DRAIN) && !stall;
            rd_addr   <= rv_nxt ? AW'(t_nxt) : '0;
            rd_valid  <= rv_nxt;
            col_valid <= (st_nxt == FEED) ? mask : '0;
            err       <= err_nxt;
        end
    end
endmodule

// File: tb/tb_sa_feed_ctrl.sv
// tb_sa_feed_ctrl: scoreboard bench for the systolic array feed controller
module tb_sa_feed_ctrl;
    localparam int N = 4;
    localparam int KMAX = 16;
    localparam int KW = 5;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic busy, done, arr_clr, arr_en, rd_valid, err;
    logic [AW-1:0] rd_addr;
    logic [N-1:0] col_valid;

    typedef struct packed {
        logic          rv;
        logic [AW-1:0] addr;
        logic [N-1:0]  col;
    } exp_t;

    exp_t q[$];
    exp_t last;
    logic have_last = 1'b0;
    int errors = 0;
    int checks = 0;

    sa_feed_ctrl #(.N(N), .KMAX(KMAX)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .k_len     (k_len),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .arr_clr   (arr_clr),
        .arr_en    (arr_en),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .col_valid (col_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    // each enabled FEED/DRAIN step consumes one expected record; stalled cycles must hold the last one
    initial begin
        forever begin
            @(negedge clk);
            if (clr_n && busy && !arr_clr && !done) begin
                if (arr_en) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL step_extra: unexpected enabled cycle rd_valid=%0b rd_addr=%0d col_valid=%b", rd_valid, rd_addr, col_valid);
                    end else begin
                        last = q.pop_front();
                        have_last = 1'b1;
                        if ({rd_valid, rd_addr, col_valid} !== last)
                            begin
                                errors++;
                                $display("FAIL step: got rv=%0b addr=%0d col=%b, want rv=%0b addr=%0d col=%b", rd_valid, rd_addr, col_valid, last.rv, last.addr, last.col);
                            end
                    end
                end else if (have_last) begin
                    checks++;
                    if ({rd_valid, rd_addr, col_valid} !== last) begin
                        errors++;
                        $display("FAIL stall_hold: got rv=%0b addr=%0d col=%b, want rv=%0b addr=%0d col=%b", rd_valid, rd_addr, col_valid, last.rv, last.addr, last.col);
                    end
                end
            end
        end
    end

    task automatic push_formula(input int k);
        exp_t e;
        for (int s = 0; s <= k + N - 2; s++) begin
            e.rv = (s < k);
            e.addr = e.rv ? AW'(s) : '0;
            for (int j = 0; j < N; j++) e.col[j] = (s >= j) && (s < j + k);
            q.push_back(e);
        end
        for (int d = 0; d < N; d++) q.push_back('0);
    endtask

    task automatic push_drain();
        for (int d = 0; d < N; d++) q.push_back('0);
    endtask

    task automatic run_job(input int k, input int sfrom, input int sn, input bit poke, input int abort_at);
        int c;
        int lat;
        lat = 1 + (k + N - 1) + N + sn;
        have_last = 1'b0;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, arr_clr, arr_en, rd_valid, done} !== 5'b11000) begin
            errors++;
            $display("FAIL clear_cycle: got busy/clr/en/rv/done=%b, want 11000", {busy, arr_clr, arr_en, rd_valid, done});
        end
        c = 0;
        while (!done && c <= lat + 20) begin
            if (c == abort_at) begin
                clr_n = 1'b0;
                stall = 1'b0;
                #1;
                checks++;
                if ({busy, done, arr_clr, arr_en, rd_addr, rd_valid, col_valid, err} !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs: got %b, want all zero", {busy, done, arr_clr, arr_en, rd_addr, rd_valid, col_valid, err});
                end
                q.delete();
                have_last = 1'b0;
                return;
            end
            stall = (c >= sfrom) && (c < sfrom + sn);
            start = poke && (c == 3);
            if (poke && c == 3) k_len = 5'd5;
            @(posedge clk); #1;
            c++;
            checks++;
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL err_spurious: got err=%0b at cycle %0d, want 0", err, c);
            end
            if (c == 1) begin
                checks++;
                if (arr_clr !== 1'b0) begin
                    errors++;
                    $display("FAIL clear_len: got arr_clr=%0b after clear cycle, want 0", arr_clr);
                end
            end
        end
        stall = 1'b0;
        start = 1'b0;
        checks++;
        if (c !== lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles, want %0d", c, lat);
        end
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL steps_left: got %0d unconsumed records, want 0", q.size());
        end
        if (poke) begin
            start = 1'b1;
            k_len = 5'd3;
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL after_done: got busy/done/err=%b, want 000", {busy, done, err});
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after: got busy/done/err=%b, want 000", {busy, done, err});
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, arr_clr, arr_en, rd_addr, rd_valid, col_valid, err} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b, want all zero", {busy, done, arr_clr, arr_en, rd_addr, rd_valid, col_valid, err});
        end
        @(posedge clk); #1;
        clr_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [N-1:0] cols [6];
        logic         rvs [6];
        exp_t e;
        cols = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
        rvs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int s = 0; s < 6; s++) begin
            e.rv = rvs[s];
            e.addr = rvs[s] ? AW'(s) : '0;
            e.col = cols[s];
            q.push_back(e);
        end
        push_drain();
        run_job(3, 100, 0, 1'b0, -1);
    endtask

    task automatic test_err();
        int bad [2];
        bad = '{0, 17};
        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            k_len = KW'(bad[i]);
            @(posedge clk); #1;
            start = 1'b0;
            checks++;
            if ({err, busy} !== 2'b10) begin
                errors++;
                $display("FAIL err_pulse k=%0d: got err/busy=%b, want 10", bad[i], {err, busy});
            end
            @(posedge clk); #1;
            checks++;
            if ({err, busy} !== 2'b00) begin
                errors++;
                $display("FAIL err_clear k=%0d: got err/busy=%b, want 00", bad[i], {err, busy});
            end
        end
    endtask

    task automatic test_stall();
        push_formula(16);
        run_job(16, 6, 3, 1'b0, -1);
    endtask

    task automatic test_ignore_start();
        push_formula(4);
        run_job(4, 100, 0, 1'b1, -1);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        push_formula(4);
        run_job(4, 100, 0, 1'b0, 3);
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold: got busy/done=%b, want 00", {busy, done});
            end
        end
        clr_n = 1'b1;
        for (int s = 0; s < N; s++) begin
            e.rv = (s == 0);
            e.addr = '0;
            e.col = N'(1) << s;
            q.push_back(e);
        end
        push_drain();
        run_job(1, 100, 0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
